// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: opcodes, control-word bit positions, idle word,
// one-hot phase encodings and helpers that build control words from the
// set of asserted signals.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word layout {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
  localparam int CON_CP  = 11;
  localparam int CON_EP  = 10;
  localparam int CON_NLM = 9;
  localparam int CON_NCE = 8;
  localparam int CON_NLI = 7;
  localparam int CON_NEI = 6;
  localparam int CON_NLA = 5;
  localparam int CON_EA  = 4;
  localparam int CON_SU  = 3;
  localparam int CON_EU  = 2;
  localparam int CON_NLB = 1;
  localparam int CON_NLO = 0;

  // Every load/enable inactive: active-low bits high, active-high bits low.
  localparam logic [11:0] CON_IDLE = 12'h3E3;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  function automatic logic [11:0] bit_m(input int idx);
    return 12'(1) << idx;
  endfunction

  // Asserting a signal means flipping its bit away from the idle level,
  // which works uniformly for active-high and active-low bits.
  function automatic logic [11:0] con_word(input logic [11:0] active);
    return CON_IDLE ^ active;
  endfunction

endpackage

// File: rtl/t_state_ring.sv
// One-hot T1..T6 phase ring. clr forces T1 asynchronously; halt empties the
// ring (all zero, which then holds); restart returns to T1 on the next edge.
module t_state_ring
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       halt,
  input  logic       restart,
  output logic [5:0] t_state
);

  logic [5:0] t_next;

  // Phase register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) t_state <= T1;
    else     t_state <= t_next;
  end

  // Rotate one phase; an all-zero ring rotates to itself, so halt is sticky
  always_comb begin
    t_next = {t_state[4:0], t_state[5]};
    if (halt)         t_next = '0;
    else if (restart) t_next = T1;
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: phase ring plus opcode decoder producing the 12-bit
// control word, with a sticky HALT flag cleared only by clr.
// Optional build macro: SEQ_VARIABLE_CYCLE_EN -- instructions end right after
// their last useful phase instead of always running six phases.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  I_sequencer,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        instr_done,
  output logic        halted
);

  logic [11:0] con_dec;
  logic        done_dec;
  logic        halt_req;
  logic        halted_q;

  assign halt_req = (t_state == T4) && (I_sequencer == OP_HLT);

  t_state_ring u_ring (
    .clk     (clk),
    .clr     (clr),
    .halt    (halt_req),
    .restart (done_dec & ~halt_req),
    .t_state (t_state)
  );

  // HALT flag: set leaving HLT's T4, held until clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr)           halted_q <= 1'b0;
    else if (halt_req) halted_q <= 1'b1;
  end

  assign halted = halted_q;

  // Decode phase and opcode into the control word and end-of-instruction flag
  always_comb begin
    con_dec  = CON_IDLE;
    done_dec = 1'b0;
    case (t_state)
      T1: con_dec = con_word(bit_m(CON_EP) | bit_m(CON_NLM));
      T2: con_dec = con_word(bit_m(CON_CP));
      T3: con_dec = con_word(bit_m(CON_NCE) | bit_m(CON_NLI));
      T4: begin
        case (I_sequencer)
          OP_LDA, OP_ADD, OP_SUB:
            con_dec = con_word(bit_m(CON_NEI) | bit_m(CON_NLM));
          OP_OUT: begin
            con_dec = con_word(bit_m(CON_EA) | bit_m(CON_NLO));
`ifdef SEQ_VARIABLE_CYCLE_EN
            done_dec = 1'b1;
`endif
          end
          OP_HLT: done_dec = 1'b1;
          default: begin
`ifdef SEQ_VARIABLE_CYCLE_EN
            done_dec = 1'b1;
`endif
          end
        endcase
      end
      T5: begin
        case (I_sequencer)
          OP_LDA: begin
            con_dec = con_word(bit_m(CON_NCE) | bit_m(CON_NLA));
`ifdef SEQ_VARIABLE_CYCLE_EN
            done_dec = 1'b1;
`endif
          end
          OP_ADD, OP_SUB:
            con_dec = con_word(bit_m(CON_NCE) | bit_m(CON_NLB));
          default: con_dec = CON_IDLE;
        endcase
      end
      T6: begin
        done_dec = 1'b1;
        case (I_sequencer)
          OP_ADD:  con_dec = con_word(bit_m(CON_NLA) | bit_m(CON_EU));
          OP_SUB:  con_dec = con_word(bit_m(CON_NLA) | bit_m(CON_SU) | bit_m(CON_EU));
          default: con_dec = CON_IDLE;
        endcase
      end
      default: begin
        con_dec  = CON_IDLE;
        done_dec = 1'b0;
      end
    endcase
  end

  // Outputs are forced quiet while clr is held
  assign con        = clr ? CON_IDLE : con_dec;
  assign instr_done = clr ? 1'b0 : done_dec;

endmodule

// File: tb/tb_controller_sequencer.sv
module tb_controller_sequencer;

  logic        clk;
  logic        clr;
  logic [3:0]  I_sequencer;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        instr_done;
  logic        halted;

  int tests;
  int failures;

  typedef struct {
    logic [5:0]  ts;
    logic [11:0] con;
    logic        done;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];

  controller_sequencer dut (
    .clk         (clk),
    .clr         (clr),
    .I_sequencer (I_sequencer),
    .con         (con),
    .t_state     (t_state),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expected phase-by-phase outputs of one instruction.
  task automatic push_instr(input logic [3:0] op, output int n);
    logic [11:0] w4, w5, w6;
    int last;
    w4 = 12'h3E3; w5 = 12'h3E3; w6 = 12'h3E3; last = 6;
    case (op)
      4'h0: begin
        w4 = 12'h1A3; w5 = 12'h2C3;
`ifdef SEQ_VARIABLE_CYCLE_EN
        last = 5;
`endif
      end
      4'h1: begin w4 = 12'h1A3; w5 = 12'h2E1; w6 = 12'h3C7; end
      4'h2: begin w4 = 12'h1A3; w5 = 12'h2E1; w6 = 12'h3CF; end
      4'hE: begin
        w4 = 12'h3F2;
`ifdef SEQ_VARIABLE_CYCLE_EN
        last = 4;
`endif
      end
      4'hF: last = 4;
      default: begin
`ifdef SEQ_VARIABLE_CYCLE_EN
        last = 4;
`endif
      end
    endcase
    exp_q.push_back('{6'b000001, 12'h5E3, 1'b0, 1'b0});
    exp_q.push_back('{6'b000010, 12'hBE3, 1'b0, 1'b0});
    exp_q.push_back('{6'b000100, 12'h263, 1'b0, 1'b0});
    exp_q.push_back('{6'b001000, w4, (last == 4), 1'b0});
    if (last >= 5) exp_q.push_back('{6'b010000, w5, (last == 5), 1'b0});
    if (last == 6) exp_q.push_back('{6'b100000, w6, 1'b1, 1'b0});
    n = last;
  endtask

  task automatic test_reset();
    exp_t e;
    clr = 1'b1;
    I_sequencer = 4'h1;
    repeat (2) @(posedge clk);
    exp_q.push_back('{6'b000001, 12'h3E3, 1'b0, 1'b0});
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
      failures++;
      $display("FAIL reset: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
               t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
    end
    I_sequencer = 4'h0;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_lda();
    exp_t e;
    int n;
    I_sequencer = 4'h0;
    push_instr(4'h0, n);
    repeat (n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL lda: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
    end
  endtask

  task automatic test_add_sub();
    exp_t e;
    int n;
    logic [3:0] ops [2];
    ops[0] = 4'h1; ops[1] = 4'h2;
    for (int k = 0; k < 2; k++) begin
      I_sequencer = ops[k];
      push_instr(ops[k], n);
      repeat (n) begin
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
          failures++;
          $display("FAIL add_sub op=%h: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                   ops[k], t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
        end
      end
    end
    // Opcode switched ADD->SUB during T6 must be followed combinationally
    I_sequencer = 4'h1;
    push_instr(4'h1, n);
    repeat (n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL add_sub live: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
    end
    #1 I_sequencer = 4'h2;
    exp_q.push_back('{6'b100000, 12'h3CF, 1'b1, 1'b0});
    #1;
    e = exp_q.pop_front();
    tests++;
    if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
      failures++;
      $display("FAIL add_sub t6_switch: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
               t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
    end
  endtask

  task automatic test_out_nop();
    exp_t e;
    int n;
    logic [3:0] ops [3];
    ops[0] = 4'hE; ops[1] = 4'h5; ops[2] = 4'h7;
    for (int k = 0; k < 3; k++) begin
      I_sequencer = ops[k];
      push_instr(ops[k], n);
      repeat (n) begin
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
          failures++;
          $display("FAIL out_nop op=%h: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                   ops[k], t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
        end
      end
    end
  endtask

  task automatic test_clr_mid();
    exp_t e;
    int n;
    I_sequencer = 4'h0;
    push_instr(4'h0, n);
    repeat (5) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL clr_mid pre: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
    end
    exp_q.delete();
    #1 clr = 1'b1;
    exp_q.push_back('{6'b000001, 12'h3E3, 1'b0, 1'b0});
    exp_q.push_back('{6'b000001, 12'h3E3, 1'b0, 1'b0});
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #1;
      else @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL clr_mid held%0d: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 k, t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
    end
    @(posedge clk);
    #1 clr = 1'b0;
    I_sequencer = 4'h1;
    push_instr(4'h1, n);
    repeat (n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL clr_mid post: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
    end
  endtask

  task automatic test_hlt();
    exp_t e;
    int n;
    I_sequencer = 4'hF;
    push_instr(4'hF, n);
    repeat (22) exp_q.push_back('{6'b000000, 12'h3E3, 1'b0, 1'b1});
    for (int k = 0; k < n + 22; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL hlt cyc%0d: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 k, t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
      // Opcode must be ignored once halted
      if (k == n) I_sequencer = 4'h0;
    end
    #1 clr = 1'b1;
    exp_q.push_back('{6'b000001, 12'h3E3, 1'b0, 1'b0});
    #1;
    e = exp_q.pop_front();
    tests++;
    if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
      failures++;
      $display("FAIL hlt clr: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
               t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
    end
    @(posedge clk);
    #1 clr = 1'b0;
    I_sequencer = 4'h0;
    push_instr(4'h0, n);
    repeat (n) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
        failures++;
        $display("FAIL hlt recover: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                 t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    logic [3:0] ops [7];
    ops[0] = 4'h0; ops[1] = 4'hE; ops[2] = 4'h1; ops[3] = 4'h9;
    ops[4] = 4'h2; ops[5] = 4'h0; ops[6] = 4'hE;
    for (int k = 0; k < 7; k++) begin
      I_sequencer = ops[k];
      push_instr(ops[k], n);
      repeat (n) begin
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if ({t_state, con, instr_done, halted} !== {e.ts, e.con, e.done, e.hlt}) begin
          failures++;
          $display("FAIL b2b #%0d op=%h: got ts=%b con=%h done=%b halted=%b want ts=%b con=%h done=%b halted=%b",
                   k, ops[k], t_state, con, instr_done, halted, e.ts, e.con, e.done, e.hlt);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    clr = 1'b1;
    I_sequencer = 4'h0;
    test_reset();
    test_lda();
    test_add_sub();
    test_out_nop();
    test_clr_mid();
    test_back_to_back();
    test_hlt();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
